// File: rtl/branch_ctrl.sv
// branch_ctrl: decodes the fetched instruction into registered branch/target/halt controls for the PC,
// resolving targets through a loadable LUT and counting retired instructions.
module branch_ctrl #(
    parameter int PC_W      = 12,
    parameter int INSTR_W   = 9,
    parameter int LUT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    prog_ct,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero_flag,
    input  logic               pc_done,
    input  logic               lut_we,
    input  logic [3:0]         lut_waddr,
    input  logic [PC_W-1:0]    lut_wdata,
    output logic               branch,
    output logic [PC_W-1:0]    target,
    output logic               halt,
    output logic               squash,
    output logic [CNT_W-1:0]   instr_count,
    output logic [1:0]         state
);
    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] SQUASH  = 2'b01;
    localparam logic [1:0] HALTED  = 2'b10;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_BNEZ = 4'b1101;
    localparam logic [3:0] OP_BEQZ = 4'b1110;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  lut_q [LUT_DEPTH];
    logic [3:0]       opcode;
    logic             run, taken, is_halt;

    always_comb begin
        run      = state_q == RUN;
        opcode   = instr[INSTR_W-1 -: 4];
        is_halt  = instr == '1;
        taken    = (opcode == OP_JMP) || (opcode == OP_BEQZ && zero_flag) || (opcode == OP_BNEZ && !zero_flag);
        state_d  = !run ? (state_q == SQUASH ? RUN : state_q) : is_halt ? HALTED : taken ? SQUASH : RUN;
        target_d = (run && taken && !is_halt) ? lut_q[instr[3:0]] : target_q;
        count_d  = run ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end

    // LUT survives reset so the harness can load it once at boot
    always_ff @(posedge clk)
        if (lut_we) lut_q[lut_waddr] <= lut_wdata;

    always @(posedge clk)
        if (!reset) assert (!(pc_done && state_q != HALTED))
            else $error("pc_done raised while not halted, pc=%h", prog_ct);

    assign branch      = state_q == SQUASH;
    assign squash      = state_q == SQUASH;
    assign halt        = state_q == HALTED;
    assign target      = target_q;
    assign instr_count = count_q;
    assign state       = state_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: table-driven vectors with an expected-result queue for branch_ctrl.
module tb_branch_ctrl;
    logic        clk = 0, reset = 1;
    logic [11:0] prog_ct = 0;
    logic [8:0]  instr = 0;
    logic        zero_flag = 0, pc_done = 0, lut_we = 0;
    logic [3:0]  lut_waddr = 0;
    logic [11:0] lut_wdata = 0;
    logic        branch, halt, squash;
    logic [11:0] target;
    logic [15:0] instr_count;
    logic [1:0]  state;
    int passed = 0, total = 0;

    typedef struct {
        logic        b;
        logic [11:0] t;
        logic        s;
        logic        h;
        logic [1:0]  st;
        logic [15:0] c;
    } exp_t;

    typedef struct {
        logic [8:0]  in;
        logic        z;
        logic        we;
        logic [3:0]  wa;
        logic [11:0] wd;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    branch_ctrl dut (
        .clk(clk), .reset(reset), .prog_ct(prog_ct), .instr(instr), .zero_flag(zero_flag),
        .pc_done(pc_done), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .branch(branch), .target(target), .halt(halt), .squash(squash),
        .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(logic b, logic [11:0] t, logic s, logic h, logic [1:0] st, logic [15:0] c);
        exp_t e;
        e.b = b; e.t = t; e.s = s; e.h = h; e.st = st; e.c = c;
        return e;
    endfunction

    function automatic vec_t mk(logic [8:0] in, logic z, logic we, logic [3:0] wa, logic [11:0] wd, exp_t e);
        vec_t v;
        v.in = in; v.z = z; v.we = we; v.wa = wa; v.wd = wd; v.e = e;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, req, $time);
    endtask

    task automatic compare(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".branch"}, 32'(branch), 32'(e.b));
        chk({tag, ".target"}, 32'(target), 32'(e.t));
        chk({tag, ".squash"}, 32'(squash), 32'(e.s));
        chk({tag, ".halt"}, 32'(halt), 32'(e.h));
        chk({tag, ".state"}, 32'(state), 32'(e.st));
        chk({tag, ".count"}, 32'(instr_count), 32'(e.c));
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        #1;
        prog_ct = prog_ct + 1'b1;
        compare(tag);
    endtask

    initial begin
        // LUT preload while held in reset: [3]=040, [2]=222, [7]=777
        lut_we = 1; lut_waddr = 3; lut_wdata = 12'h040;
        @(posedge clk); #1;
        lut_waddr = 2; lut_wdata = 12'h222;
        @(posedge clk); #1;
        lut_waddr = 7; lut_wdata = 12'h777;
        @(posedge clk); #1;
        lut_we = 0; reset = 0; prog_ct = 12'h005;
        sb.push_back(ex(0, 12'h000, 0, 0, 2'd0, 16'd0));
        compare("reset");

        vecs.push_back(mk(9'h183, 0, 0, 0, 0, ex(1, 12'h040, 1, 0, 2'd1, 16'd1)));
        vecs.push_back(mk(9'h183, 0, 0, 0, 0, ex(0, 12'h040, 0, 0, 2'd0, 16'd1)));
        vecs.push_back(mk(9'h1A2, 1, 0, 0, 0, ex(0, 12'h040, 0, 0, 2'd0, 16'd2)));
        vecs.push_back(mk(9'h1C2, 1, 0, 0, 0, ex(1, 12'h222, 1, 0, 2'd1, 16'd3)));
        vecs.push_back(mk(9'h000, 0, 0, 0, 0, ex(0, 12'h222, 0, 0, 2'd0, 16'd3)));
        vecs.push_back(mk(9'h1C2, 0, 0, 0, 0, ex(0, 12'h222, 0, 0, 2'd0, 16'd4)));
        vecs.push_back(mk(9'h1A3, 0, 0, 0, 0, ex(1, 12'h040, 1, 0, 2'd1, 16'd5)));
        vecs.push_back(mk(9'h1FF, 0, 0, 0, 0, ex(0, 12'h040, 0, 0, 2'd0, 16'd5)));
        vecs.push_back(mk(9'h187, 0, 1, 7, 12'h123, ex(1, 12'h777, 1, 0, 2'd1, 16'd6)));
        vecs.push_back(mk(9'h000, 0, 0, 0, 0, ex(0, 12'h777, 0, 0, 2'd0, 16'd6)));
        vecs.push_back(mk(9'h187, 0, 0, 0, 0, ex(1, 12'h123, 1, 0, 2'd1, 16'd7)));
        vecs.push_back(mk(9'h000, 0, 0, 0, 0, ex(0, 12'h123, 0, 0, 2'd0, 16'd7)));
        vecs.push_back(mk(9'h1E0, 0, 0, 0, 0, ex(0, 12'h123, 0, 0, 2'd0, 16'd8)));
        vecs.push_back(mk(9'h1FF, 0, 0, 0, 0, ex(0, 12'h123, 0, 1, 2'd2, 16'd9)));

        foreach (vecs[i]) begin
            instr = vecs[i].in; zero_flag = vecs[i].z;
            lut_we = vecs[i].we; lut_waddr = vecs[i].wa; lut_wdata = vecs[i].wd;
            sb.push_back(vecs[i].e);
            tick($sformatf("vec%0d", i));
        end

        // halted: random instructions ignored, count frozen, LUT[5] still writable
        for (int i = 0; i < 20; i++) begin
            instr = 9'($urandom_range(0, 511)); zero_flag = 1'($urandom_range(0, 1));
            pc_done = 1; lut_we = (i == 5); lut_waddr = 5; lut_wdata = 12'h555;
            sb.push_back(ex(0, 12'h123, 0, 1, 2'd2, 16'd9));
            tick($sformatf("halted%0d", i));
        end

        pc_done = 0; lut_we = 0; reset = 1; instr = 9'h183;
        sb.push_back(ex(0, 12'h000, 0, 0, 2'd0, 16'd0));
        tick("rst_halt");
        reset = 0; instr = 9'h185;
        sb.push_back(ex(1, 12'h555, 1, 0, 2'd1, 16'd1));
        tick("jmp_lut5");
        reset = 1; instr = 9'h000;
        sb.push_back(ex(0, 12'h000, 0, 0, 2'd0, 16'd0));
        tick("rst_squash");
        reset = 0;

        for (int i = 0; i < 65535; i++) @(posedge clk);
        #1;
        sb.push_back(ex(0, 12'h000, 0, 0, 2'd0, 16'hFFFF));
        compare("cnt_max");
        sb.push_back(ex(0, 12'h000, 0, 0, 2'd0, 16'h0000));
        tick("cnt_wrap");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
